// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: opcode and state encodings,
// field widths and small opcode-class helpers.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned RA_W    = 3;

  // ALU operations occupy 0..15; control/memory opcodes follow; 22..31 are undefined.
  typedef enum logic [OP_W-1:0] {
    OP_MOVE  = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_OR    = 5'd3,
    OP_AND   = 5'd4,
    OP_XOR   = 5'd5,
    OP_NOT   = 5'd6,
    OP_ROR   = 5'd7,
    OP_ROL   = 5'd8,
    OP_SAL   = 5'd9,
    OP_SAR   = 5'd10,
    OP_CMP1  = 5'd11,
    OP_CMP2  = 5'd12,
    OP_NXOR  = 5'd13,
    OP_ADDI  = 5'd14,
    OP_SUBI  = 5'd15,
    OP_LOAD  = 5'd16,
    OP_STORE = 5'd17,
    OP_JMP   = 5'd18,
    OP_BZ    = 5'd19,
    OP_HALT  = 5'd20,
    OP_NOP   = 5'd21
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Register-writing ALU instruction (everything below the memory opcodes).
  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_SUBI);
  endfunction

  // Immediate-operand ALU instruction.
  function automatic logic is_imm(input logic [OP_W-1:0] op);
    return (op == OP_W'(OP_ADDI)) || (op == OP_W'(OP_SUBI));
  endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: fetches over a req/ack port, decodes the opcode
// and sequences ALU, register file and data memory.
// Ports:
//   clk, rst (sync, active-high), start        - clocking / kick-off
//   imem_req/imem_ack/instr, pc                 - instruction fetch port
//   alu_op, rf_ra1/rf_ra2/rf_wa, rf_we, wb_sel  - datapath control
//   sel_imm, imm, alu_zero                      - operand select / ALU status
//   dmem_req/dmem_we/dmem_ack                   - data memory handshake
//   halted, illegal                             - status (illegal is sticky)
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     pc,
  output logic [OP_W-1:0]     alu_op,
  output logic [RA_W-1:0]     rf_ra1,
  output logic [RA_W-1:0]     rf_ra2,
  output logic [RA_W-1:0]     rf_wa,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                sel_imm,
  output logic [INSTR_W-1:0]  imm,
  input  logic                alu_zero,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                halted,
  output logic                illegal
);

  state_e              state, state_n;
  logic [INSTR_W-1:0]  ir, ir_n;
  logic [PC_W-1:0]     pc_n;
  logic                illegal_n;
  logic                imem_req_n, dmem_req_n, dmem_we_n, rf_we_n, wb_sel_n, halted_n;
  logic [OP_W-1:0]     op;

  assign op = ir[15:11];

  // Fields decoded straight from IR: stable from DECODE until the next fetch ack.
  assign alu_op  = (op == OP_W'(OP_BZ)) ? OP_W'(OP_MOVE) : op;
  assign rf_ra1  = ir[7:5];
  assign rf_ra2  = ir[4:2];
  assign rf_wa   = ir[10:8];
  assign sel_imm = is_imm(op);
  assign imm     = sel_imm ? INSTR_W'(ir[4:0]) : INSTR_W'(ir[7:0]);

  // Next state, next PC/IR and next registered strobes.
  always_comb begin
    state_n   = state;
    ir_n      = ir;
    pc_n      = pc;
    illegal_n = illegal;
    unique case (state)
      S_IDLE:   if (start) state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_n    = instr;
          pc_n    = pc + PC_W'(1);
          state_n = S_DECODE;
        end
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (is_alu(op)) begin
          state_n = S_WB;
        end else begin
          case (op)
            OP_W'(OP_LOAD), OP_W'(OP_STORE): state_n = S_MEM;
            OP_W'(OP_JMP): begin
              pc_n    = PC_W'(ir[7:0]);
              state_n = S_FETCH;
            end
            OP_W'(OP_BZ): begin
              if (alu_zero) pc_n = PC_W'(ir[7:0]);
              state_n = S_FETCH;
            end
            OP_W'(OP_HALT): state_n = S_HALT;
            OP_W'(OP_NOP):  state_n = S_FETCH;
            default: begin
              illegal_n = 1'b1;
              state_n   = S_FETCH;
            end
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack) state_n = (op == OP_W'(OP_LOAD)) ? S_WB : S_FETCH;
      end
      S_WB:     state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase

    // Strobes follow the state being entered so they are valid for its whole duration.
    imem_req_n = (state_n == S_FETCH);
    dmem_req_n = (state_n == S_MEM);
    dmem_we_n  = (state_n == S_MEM) && (op == OP_W'(OP_STORE));
    rf_we_n    = (state_n == S_WB);
    wb_sel_n   = (state_n == S_WB) && (op == OP_W'(OP_LOAD));
    halted_n   = (state_n == S_HALT);
  end

  // State, PC, IR and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= '0;
      pc       <= '0;
      illegal  <= 1'b0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      ir       <= ir_n;
      pc       <= pc_n;
      illegal  <= illegal_n;
      imem_req <= imem_req_n;
      dmem_req <= dmem_req_n;
      dmem_we  <= dmem_we_n;
      rf_we    <= rf_we_n;
      wb_sel   <= wb_sel_n;
      halted   <= halted_n;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed instructions followed by a random
// program, each checked against a per-instruction transaction model.
module tb_cpu_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, alu_zero, dmem_ack;
  logic [15:0] instr;
  logic        imem_req, rf_we, wb_sel, sel_imm, dmem_req, dmem_we, halted, illegal;
  logic [7:0]  pc;
  logic [4:0]  alu_op;
  logic [2:0]  rf_ra1, rf_ra2, rf_wa;
  logic [15:0] imm;

  int total = 0;
  int bad   = 0;
  int mpc   = 0;
  bit mill  = 1'b0;

  cpu_ctrl #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr), .pc(pc),
    .alu_op(alu_op), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa),
    .rf_we(rf_we), .wb_sel(wb_sel), .sel_imm(sel_imm), .imm(imm),
    .alu_zero(alu_zero), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, imem_req, 0);
    check({tag, "_dmem_req"}, dmem_req, 0);
    check({tag, "_dmem_we"},  dmem_we,  0);
    check({tag, "_rf_we"},    rf_we,    0);
    check({tag, "_sel_imm"},  sel_imm,  0);
    check({tag, "_wb_sel"},   wb_sel,   0);
    check({tag, "_halted"},   halted,   0);
    check({tag, "_illegal"},  illegal,  0);
    check({tag, "_pc"},       pc,       0);
    check({tag, "_alu_op"},   alu_op,   0);
  endtask

  // Drive one instruction through fetch..completion and compare against the model.
  task automatic run_instr(input logic [15:0] iw, input int iwait, input int dwait, input bit z);
    logic [4:0] op;
    int   n, rfwe_n, dreq_n, exp_cyc, exp_dreq, exp_rfwe, nxt;
    bit   ismem, isalu;
    logic [4:0]  exp_op;
    logic [15:0] exp_imm;

    op    = iw[15:11];
    isalu = (op <= 5'd15);
    ismem = (op == OP_LOAD) || (op == OP_STORE);
    exp_op   = (op == OP_BZ) ? 5'd0 : op;
    exp_imm  = (op == OP_ADDI || op == OP_SUBI) ? {11'd0, iw[4:0]} : {8'd0, iw[7:0]};
    exp_dreq = ismem ? dwait + 1 : 0;
    exp_rfwe = (isalu || op == OP_LOAD) ? 1 : 0;
    if (isalu)                 exp_cyc = 4;
    else if (op == OP_LOAD)    exp_cyc = 5 + dwait;
    else if (op == OP_STORE)   exp_cyc = 4 + dwait;
    else                       exp_cyc = 3;
    nxt = (mpc + 1) % 256;
    if (op == OP_JMP || (op == OP_BZ && z)) nxt = int'(iw[7:0]);
    if (op > 5'd21) mill = 1'b1;

    start = 1'($urandom_range(0, 1));
    check("pc_at_fetch", pc, mpc);
    check("imem_req", imem_req, 1);
    alu_zero = z;
    for (int i = 0; i < iwait; i++) begin
      step();
      check("imem_req_hold", imem_req, 1);
    end
    imem_ack = 1'b1;
    instr    = iw;
    step();
    imem_ack = 1'b0;
    instr    = 16'($urandom);
    check("pc_incr", pc, (mpc + 1) % 256);

    n = 1; rfwe_n = 0; dreq_n = 0;
    while (!imem_req && !halted && n < 40) begin
      check("alu_op", alu_op, exp_op);
      check("sel_imm", sel_imm, (op == OP_ADDI || op == OP_SUBI));
      check("imm", imm, exp_imm);
      check("rf_addr", {rf_ra1, rf_ra2, rf_wa}, {iw[7:5], iw[4:2], iw[10:8]});
      if (rf_we) begin
        rfwe_n++;
        check("wb_sel", wb_sel, (op == OP_LOAD));
      end
      if (dmem_req) begin
        dreq_n++;
        check("dmem_we", dmem_we, (op == OP_STORE));
        if (dreq_n == dwait + 1) dmem_ack = 1'b1;
      end else begin
        check("dmem_we_idle", dmem_we, 0);
      end
      step();
      dmem_ack = 1'b0;
      n++;
    end
    start = 1'b0;
    check("cycles", n, exp_cyc);
    check("rf_we_count", rfwe_n, exp_rfwe);
    check("dmem_req_cycles", dreq_n, exp_dreq);
    check("illegal", illegal, mill);
    check("halted", halted, (op == OP_HALT));
    if (op != OP_HALT) check("pc_next", pc, nxt);
    mpc = nxt;
  endtask

  function automatic logic [15:0] mk(input opcode_e op, input logic [10:0] rest);
    return {5'(op), rest};
  endfunction

  initial begin
    logic [31:0] r;
    int op, iw_wait, dw;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    alu_zero = 1'b0; instr = '0;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("reset");
    // A late ack while idle must not move anything.
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    check("idle_ack_pc", pc, 0);
    check("idle_ack_req", imem_req, 0);

    start = 1'b1; step(); start = 1'b0;
    run_instr(mk(OP_ADD,  {3'd3, 3'd1, 3'd2, 2'd0}), 0, 0, 0);
    run_instr(mk(OP_ADDI, {3'd1, 3'd1, 5'd5}), 0, 0, 0);
    run_instr(mk(OP_LOAD, {3'd4, 3'd2, 3'd0, 2'd0}), 0, 3, 0);
    run_instr(mk(OP_STORE,{3'd0, 3'd2, 3'd5, 2'd0}), 1, 0, 0);
    run_instr(mk(OP_BZ,   {3'd0, 8'h40}), 0, 0, 1);
    run_instr(mk(OP_BZ,   {3'd0, 8'h40}), 0, 0, 0);
    run_instr(mk(OP_JMP,  {3'd0, 8'hFF}), 0, 0, 0);
    run_instr(mk(OP_NOP,  11'd0), 0, 0, 0);
    run_instr(mk(OP_JMP,  {3'd0, 8'hFF}), 0, 0, 0);
    run_instr(mk(OP_JMP,  {3'd0, 8'h12}), 2, 0, 0);
    run_instr({5'd27, 11'h155}, 0, 0, 0);
    run_instr(mk(OP_SUBI, {3'd2, 3'd6, 5'd31}), 0, 0, 0);

    for (int k = 0; k < 250; k++) begin
      r  = $urandom;
      op = int'($urandom_range(0, 31));
      if (op == int'(OP_HALT)) op = int'(OP_NOP);
      iw_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      dw      = int'($urandom_range(0, 3));
      run_instr({5'(op), r[10:0]}, iw_wait, dw, r[31]);
    end

    run_instr(mk(OP_HALT, 11'd0), 0, 0, 0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_no_fetch", imem_req, 0);
      check("halt_stays", halted, 1);
    end
    start = 1'b0;

    // Reset while a fetch is waiting on its ack.
    rst = 1'b1; step(); rst = 1'b0;
    mpc = 0; mill = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    run_instr(mk(OP_NOP, 11'd0), 0, 0, 0);
    step(); step();
    check("wait_req", imem_req, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_reset_outputs("midrst");
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    check("late_ack_pc", pc, 0);
    check("late_ack_req", imem_req, 0);
    mpc = 0;
    start = 1'b1; step(); start = 1'b0;
    run_instr(mk(OP_ADD, {3'd7, 3'd0, 3'd1, 2'd0}), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
